// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   UART_DATA_W    : byte width carried from host to transmitter
//   BUSY_TIMEOUT   : cycles of low tx_busy after a launch before the frame is
//                    treated as finished or missed
//   launch_state_t : launcher FSM states
package uart_pkg;

   localparam int unsigned UART_DATA_W  = 8;
   localparam int unsigned BUSY_TIMEOUT = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } launch_state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Circular byte FIFO with wrap-bit pointers.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   wr_data   : byte to enqueue
//   wr_valid  : push request, taken when wr_ready is high
//   wr_ready  : not full (pointer-derived, independent of same-cycle pop)
//   pop       : advance read pointer (ignored when empty)
//   rd_data   : byte at the read pointer (combinational)
//   level     : occupancy 0..DEPTH
//   empty     : level == 0
module sync_byte_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic                   pop,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]        level,
   output logic                   empty
);

   logic [UART_DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]        wr_ptr;
   logic [ADDR_W:0]        rd_ptr;
   logic                   full;
   logic                   push;

   // Wrap bits differ with equal low bits: the writer is one lap ahead.
   assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign wr_ready = !full;
   assign push     = wr_valid && !full;
   assign level    = wr_ptr - rd_ptr;
   assign rd_data  = mem[rd_ptr[ADDR_W-1:0]];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)           wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
         if (pop && !empty)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launcher feeding a UART transmitter.
// Ports:
//   clk_50m   : system clock, rising edge
//   rst       : asynchronous active-high reset
//   wr_data   : host byte to enqueue
//   wr_valid  : host push request
//   wr_ready  : FIFO not full
//   tx_busy   : transmitter busy flag
//   din       : byte to transmitter, held until the next launch
//   wr_en     : one-cycle launch strobe to transmitter
//   level     : FIFO occupancy 0..DEPTH
//   empty     : FIFO empty
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                   clk_50m,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic                   tx_busy,
   output logic [UART_DATA_W-1:0] din,
   output logic                   wr_en,
   output logic [ADDR_W:0]        level,
   output logic                   empty
);

   localparam logic [2:0] TIMEOUT_LAST = 3'(BUSY_TIMEOUT - 1);

   launch_state_t          state;
   launch_state_t          state_next;
   logic [2:0]             idle_cnt;
   logic [2:0]             idle_cnt_next;
   logic                   launch;
   logic [UART_DATA_W-1:0] rd_data;

   sync_byte_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk      (clk_50m),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .pop      (launch),
      .rd_data  (rd_data),
      .level    (level),
      .empty    (empty)
   );

   always_comb begin
      state_next    = state;
      idle_cnt_next = idle_cnt;
      launch        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               launch     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            idle_cnt_next = '0;
            state_next    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // A transmitter that never raises busy must not stall the queue.
            if (tx_busy)                      state_next    = WAIT_DONE;
            else if (idle_cnt == TIMEOUT_LAST) state_next    = IDLE;
            else                              idle_cnt_next = idle_cnt + 3'd1;
         end
         WAIT_DONE: begin
            if (!tx_busy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idle_cnt <= '0;
         wr_en    <= 1'b0;
         din      <= '0;
      end else begin
         state    <= state_next;
         idle_cnt <= idle_cnt_next;
         wr_en    <= launch;
         if (launch) din <= rd_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed phases with random data,
// checked against a queue-based model of the FIFO and launcher rules.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;

   logic       clk_50m = 1'b0;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic       tx_busy;
   logic [7:0] din;
   logic       wr_en;
   logic [4:0] level;
   logic       empty;

   uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk_50m  (clk_50m),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .tx_busy  (tx_busy),
      .din      (din),
      .wr_en    (wr_en),
      .level    (level),
      .empty    (empty)
   );

   always #10 clk_50m = ~clk_50m;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   int  cyc = 0;
   int  launches = 0;
   int  last_launch = -100;
   int  fall_cyc = -100;
   int  accepted = 0;
   int  busy_cnt = 0;
   bit  uart_on = 0;
   bit  chk_spacing = 0;
   int  spaced = 0;
   bit  prev_wr_en = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: update the model with what the DUT saw at the edge, then check.
   task automatic tick();
      int  pre_size;
      bit  busy_pre;
      bit  acc;
      bit  old_busy;
      logic [7:0] exp_b;
      busy_pre = tx_busy;
      @(posedge clk_50m);
      #1;
      cyc++;
      pre_size = q.size();
      acc = wr_valid && (pre_size < DEPTH);
      if (wr_en) begin
         check("launch_nonempty", 32'(pre_size > 0), 32'd1);
         check("launch_busy_low", 32'(busy_pre), 32'd0);
         check("pulse_one_cycle", 32'(prev_wr_en), 32'd0);
         if (uart_on && fall_cyc > last_launch)
            check("gap_after_fall", 32'((cyc - fall_cyc) >= 2), 32'd1);
         if (chk_spacing && spaced > 0)
            check("timeout_spacing", 32'(cyc - last_launch), 32'd6);
         if (chk_spacing) spaced++;
         if (pre_size > 0) begin
            exp_b = q.pop_front();
            check("din_order", 32'(din), 32'(exp_b));
         end
         launches++;
         last_launch = cyc;
      end
      if (acc) begin
         q.push_back(wr_data);
         accepted++;
      end
      prev_wr_en = wr_en;
      check("level", 32'(level), 32'(q.size()));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
      if (uart_on) begin
         old_busy = tx_busy;
         if (wr_en) busy_cnt = 10;
         else if (busy_cnt > 0) busy_cnt--;
         tx_busy = (busy_cnt > 0);
         if (old_busy && !tx_busy) fall_cyc = cyc;
      end
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while (q.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      check("drain_bound", 32'(q.size()), 32'd0);
      repeat (20) tick();
   endtask

   initial begin
      int l0;
      int n;
      rst = 1'b1; wr_data = '0; wr_valid = 1'b0; tx_busy = 1'b0;
      #5;
      check("rst_level", 32'(level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_ready", 32'(wr_ready), 32'd1);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_din", 32'(din), 32'd0);
      @(posedge clk_50m); #1;
      rst = 1'b0;
      tick();

      // Single byte latency
      wr_valid = 1'b1; wr_data = 8'hA5;
      tick();
      wr_valid = 1'b0;
      check("single_not_yet", 32'(wr_en), 32'd0);
      tick();
      check("single_strobe", 32'(wr_en), 32'd1);
      check("single_din", 32'(din), 32'hA5);
      tick();
      check("single_drop", 32'(wr_en), 32'd0);
      check("single_din_hold", 32'(din), 32'hA5);
      repeat (10) tick();

      // Asynchronous reset mid-burst
      tx_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_data = 8'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      check("pre_rst_level", 32'(level), 32'd5);
      #4 rst = 1'b1;
      #1;
      check("arst_level", 32'(level), 32'd0);
      check("arst_empty", 32'(empty), 32'd1);
      check("arst_wr_en", 32'(wr_en), 32'd0);
      check("arst_din", 32'(din), 32'd0);
      check("arst_ready", 32'(wr_ready), 32'd1);
      q.delete();
      #3 rst = 1'b0;
      tx_busy = 1'b0;
      repeat (3) tick();

      // Burst against a UART that stays busy 10 cycles per byte
      uart_on = 1; busy_cnt = 0;
      l0 = launches;
      wr_valid = 1'b1;
      wr_data = 8'h48; tick();
      wr_data = 8'h69; tick();
      wr_data = 8'h21; tick();
      wr_valid = 1'b0;
      drain(200);
      check("burst_launches", 32'(launches - l0), 32'd3);

      // Fill past full with the transmitter held busy
      uart_on = 0; tx_busy = 1'b1;
      l0 = launches;
      for (int i = 0; i < 17; i++) begin
         wr_valid = 1'b1; wr_data = 8'($urandom);
         tick();
         if (i == 15) check("full_ready_low", 32'(wr_ready), 32'd0);
      end
      wr_valid = 1'b0;
      check("full_level", 32'(level), 32'd16);
      check("full_no_launch", 32'(launches - l0), 32'd0);

      // Keep pushing while the full FIFO drains: pointers wrap
      uart_on = 1; busy_cnt = 0; tx_busy = 1'b0;
      accepted = 0;
      n = 0;
      while (accepted < 40 && n < 2000) begin
         wr_valid = 1'b1; wr_data = 8'($urandom);
         tick();
         n++;
      end
      wr_valid = 1'b0;
      check("wrap_push_bound", 32'(accepted >= 40), 32'd1);
      drain(1000);

      // Sparse random pushes against the timeout-paced launcher
      uart_on = 0; tx_busy = 1'b0;
      for (int i = 0; i < 200; i++) begin
         wr_valid = ($urandom_range(0, 3) == 0);
         wr_data = 8'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      drain(500);

      // Missed busy: each byte launched once, six cycles apart
      l0 = launches;
      chk_spacing = 1; spaced = 0;
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 8'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      repeat (30) tick();
      check("missed_launches", 32'(launches - l0), 32'd3);
      check("missed_empty", 32'(empty), 32'd1);
      chk_spacing = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
